tdc_hit_encoder: RTL and testbench
==================================

TDC_HIT_ENCODER -- requirements
Module: tdc_hit_encoder

Interface
REQ-001 SHALL have parameter NTAP, default 55: delay-line tap count, i.e. fine raw code width.
REQ-002 SHALL have parameter FINE_W, default 7: fine binary code width; must be at least clog2(NTAP+1).
REQ-003 SHALL have parameter CNT_W, default 5: width of each coarse counter.
REQ-004 SHALL have parameter SEL_THR, default 28: fine-code threshold at or above which counterB is used as coarse.
REQ-005 SHALL have parameter DEPTH, default 8: output FIFO depth; must be a power of 2 and at least 2.
REQ-006 clk40M  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 hit_valid  input  1  one-cycle strobe qualifying fine_raw_code, counterA and counterB.
REQ-009 fine_raw_code  input  NTAP  thermometer-coded delay-line sample; bit 0 is the first tap.
REQ-010 counterA, counterB  input  CNT_W each  coarse counters sampled on opposite clock phases.
REQ-011 enc_mode  input  1  0 = ones-count encoding; 1 = first 1-to-0 transition position.
REQ-012 out_data  output  1+CNT_W+FINE_W  FIFO head word {err, coarse, fine}.
REQ-013 out_valid / out_ready  output / input  1 each  valid-ready handshake; a word transfers when both are 1.
REQ-014 fifo_count  output  clog2(DEPTH)+1  number of words held in the FIFO.
REQ-015 ovf  output  1  sticky overflow flag.
REQ-016 clr_ovf  input  1  one-cycle pulse that clears ovf.

Function
REQ-017 Stage 1 SHALL register hit_valid, fine_raw_code, counterA, counterB and enc_mode.
REQ-018 Stage 2 SHALL bubble-correct each bit as the 3-input majority of raw[i-1], raw[i], raw[i+1]; out-of-range neighbours are replaced by raw[i].
REQ-019 Mode 0: fine SHALL be the number of 1s in the corrected code.
REQ-020 Mode 1: fine SHALL be the lowest index i with corr[i]=1 and corr[i+1]=0.
- If no such i exists, fine SHALL be 0 for an all-zero code and NTAP for an all-one code.
REQ-021 coarse SHALL be counterB when fine >= SEL_THR, otherwise counterA.
REQ-022 err SHALL be 1 when the corrected code contains more than one 0-to-1 or 1-to-0 transition.
REQ-023 An encoded word SHALL be pushed into the FIFO at the end of stage 2.
- Latency: a hit at edge N is visible on out_data/out_valid after edge N+2 when the FIFO was empty.
REQ-024 The FIFO SHALL be first-in first-out.
- out_valid = (fifo_count != 0).
- out_data holds the head word; it is stable while out_valid=1 and out_ready=0.
REQ-025 Push while full without a simultaneous pop SHALL drop the new word and set ovf; FIFO contents are unchanged.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full (fifo_count unchanged) and when empty-with-push-in-flight.
REQ-027 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-028 clr_ovf together with a new overflow in the same cycle: ovf SHALL remain 1 (set wins).
REQ-029 Back-to-back hit_valid on every cycle SHALL be accepted at full throughput.

Reset
REQ-030 On rst, the following SHALL clear asynchronously to 0:
- out_valid, fifo_count, ovf, out_data
- all pipeline valid bits
- FIFO pointers
REQ-031 A hit in flight when rst asserts SHALL be discarded; the first hit after rst deassertion SHALL behave as in REQ-023.

Structure
REQ-032 Package tdc_pkg SHALL hold the default NTAP/FINE_W/CNT_W/SEL_THR values, the word field offsets and the enc_mode encodings.
REQ-033 The FIFO SHALL be a separate sub-module, tdc_sync_fifo, parametrised by width and DEPTH.

Verification
REQ-034 Directed scenarios (defaults, out_ready=1 unless stated):
- Mode 0, raw bits 0..19 = 1, counterA=3 -> out_data {0, 3, 20} at N+2.
- Mode 0, bits 0..19 = 1 except bit 10 = 0 -> fine 20, err 0. Same code with bits 30..32 also = 1 -> err 1.
- Raw bits 0..29 = 1, counterA=3, counterB=9 -> coarse 9, fine 30. Raw bits 0..27 = 1 -> coarse 9 (threshold boundary).
- Mode 1: raw bits 0..40 = 1 -> fine 40. All-zero -> 0. All-one -> 55.
- out_ready=0, 9 consecutive hits -> fifo_count 8, ovf 1. Then out_ready=1 -> the first 8 words drain in order. clr_ovf -> ovf 0.
- rst asserted one cycle after a hit -> no word emitted, all outputs 0. Hit after release -> word at N+2.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants and types for the TDC hit encoder.
//   - default delay-line geometry and coarse-counter widths
//   - bit offsets of the {err, coarse, fine} output word (default geometry)
//   - enc_mode encodings
package tdc_pkg;

    localparam int NTAP_DEF    = 55;
    localparam int FINE_W_DEF  = 7;
    localparam int CNT_W_DEF   = 5;
    localparam int SEL_THR_DEF = 28;

    // Word layout, LSB first: fine | coarse | err
    localparam int FINE_LSB   = 0;
    localparam int COARSE_LSB = FINE_W_DEF;
    localparam int ERR_BIT    = FINE_W_DEF + CNT_W_DEF;
    localparam int WORD_W_DEF = 1 + CNT_W_DEF + FINE_W_DEF;

    typedef enum logic {
        ENC_ONES  = 1'b0,  // fine = number of ones in corrected code
        ENC_TRANS = 1'b1   // fine = position of first 1->0 transition
    } enc_mode_e;

endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: single-clock first-in first-out buffer.
//   clk40M, rst   : clock, asynchronous active-high reset
//   push, din     : write request and data; dropped when full without a pop
//   pop           : read request; ignored when empty
//   dout          : head word, forced to 0 while empty
//   count         : words held (0..DEPTH)
//   dropped       : one-cycle flag, a push was rejected this cycle
module tdc_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                       clk40M,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO still accepts the word.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk40M) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder: converts a thermometer-coded delay-line sample plus two
// coarse counters into a {err, coarse, fine} word and queues it in a FIFO.
//   clk40M, rst            : clock, asynchronous active-high reset
//   hit_valid              : strobe qualifying fine_raw_code/counterA/counterB
//   fine_raw_code          : delay-line sample, bit 0 = first tap
//   counterA, counterB     : coarse counters sampled on opposite clock phases
//   enc_mode               : 0 = ones count, 1 = first 1->0 transition
//   out_data/out_valid/out_ready : FIFO head with valid-ready handshake
//   fifo_count             : words held in the FIFO
//   ovf, clr_ovf           : sticky overflow flag and its clear pulse
// Pipeline: stage 1 registers the inputs, stage 2 registers the encoded
// word, the FIFO write follows, so a hit is at the FIFO head two edges
// after it is sampled.
module tdc_hit_encoder
    import tdc_pkg::*;
#(
    parameter int NTAP    = NTAP_DEF,
    parameter int FINE_W  = FINE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SEL_THR = SEL_THR_DEF,
    parameter int DEPTH   = 8
) (
    input  logic                        clk40M,
    input  logic                        rst,
    input  logic                        hit_valid,
    input  logic [NTAP-1:0]             fine_raw_code,
    input  logic [CNT_W-1:0]            counterA,
    input  logic [CNT_W-1:0]            counterB,
    input  logic                        enc_mode,
    output logic [CNT_W+FINE_W:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        ovf,
    input  logic                        clr_ovf
);

    localparam int WORD_W = 1 + CNT_W + FINE_W;
    localparam logic [FINE_W-1:0] NTAP_F    = FINE_W'(NTAP);
    localparam logic [FINE_W-1:0] SEL_THR_F = FINE_W'(SEL_THR);

    // Stage 1: input capture
    logic             s1_valid;
    logic [NTAP-1:0]  s1_raw;
    logic [CNT_W-1:0] s1_cnt_a;
    logic [CNT_W-1:0] s1_cnt_b;
    enc_mode_e        s1_mode;

    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_cnt_a <= '0;
            s1_cnt_b <= '0;
            s1_mode  <= ENC_ONES;
        end else begin
            s1_valid <= hit_valid;
            s1_raw   <= fine_raw_code;
            s1_cnt_a <= counterA;
            s1_cnt_b <= counterB;
            s1_mode  <= enc_mode_e'(enc_mode);
        end
    end

    // Bubble correction: 3-tap majority; at the ends the missing neighbour
    // is replaced by the bit itself, which leaves end bits unchanged.
    logic [NTAP-1:0] corr;

    for (genvar g = 0; g < NTAP; g++) begin : g_corr
        logic lo;
        logic hi;
        if (g == 0) begin : g_lo_edge
            assign lo = s1_raw[g];
        end else begin : g_lo_mid
            assign lo = s1_raw[g-1];
        end
        if (g == NTAP - 1) begin : g_hi_edge
            assign hi = s1_raw[g];
        end else begin : g_hi_mid
            assign hi = s1_raw[g+1];
        end
        assign corr[g] = (lo & s1_raw[g]) | (lo & hi) | (s1_raw[g] & hi);
    end

    // Per-boundary flags between tap j and tap j+1
    logic [NTAP-2:0] trans;
    logic [NTAP-2:0] fall;

    assign trans = corr[NTAP-2:0] ^ corr[NTAP-1:1];
    assign fall  = corr[NTAP-2:0] & ~corr[NTAP-1:1];

    logic [FINE_W-1:0] ones_cnt;
    logic [FINE_W-1:0] fall_pos;
    logic              fall_found;
    logic              trans_seen;
    logic              trans_multi;
    logic [FINE_W-1:0] fine_c;
    logic [CNT_W-1:0]  coarse_c;

    always_comb begin
        ones_cnt    = '0;
        fall_pos    = '0;
        fall_found  = 1'b0;
        trans_seen  = 1'b0;
        trans_multi = 1'b0;
        for (int i = 0; i < NTAP; i++) begin
            ones_cnt = ones_cnt + FINE_W'(corr[i]);
        end
        for (int j = 0; j < NTAP - 1; j++) begin
            if (trans[j]) begin
                if (trans_seen) trans_multi = 1'b1;
                trans_seen = 1'b1;
            end
            if (!fall_found && fall[j]) begin
                fall_pos   = FINE_W'(j);
                fall_found = 1'b1;
            end
        end

        if (s1_mode == ENC_ONES) begin
            fine_c = ones_cnt;
        end else if (fall_found) begin
            fine_c = fall_pos;
        end else if (corr[NTAP-1]) begin
            // No falling edge inside the line but the last tap is set:
            // the edge ran past the end of the line.
            fine_c = NTAP_F;
        end else begin
            fine_c = '0;
        end

        // Late fine codes sit near the next coarse tick, where counterB
        // (sampled on the other phase) is the settled value.
        coarse_c = (fine_c >= SEL_THR_F) ? s1_cnt_b : s1_cnt_a;
    end

    // Stage 2: encoded word register
    logic              s2_valid;
    logic [WORD_W-1:0] s2_word;

    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_word  <= {trans_multi, coarse_c, fine_c};
        end
    end

    // Output FIFO
    logic fifo_pop;
    logic fifo_dropped;

    assign out_valid = (fifo_count != '0);
    assign fifo_pop  = out_valid && out_ready;

    tdc_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk40M  (clk40M),
        .rst     (rst),
        .push    (s2_valid),
        .din     (s2_word),
        .pop     (fifo_pop),
        .dout    (out_data),
        .count   (fifo_count),
        .dropped (fifo_dropped)
    );

    // Set has priority so an overflow coinciding with clr_ovf is not lost.
    always_ff @(posedge clk40M or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (fifo_dropped) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// tb_tdc_hit_encoder: scoreboard bench for tdc_hit_encoder.
// Expected words are queued when a hit is driven and compared when the
// DUT hands the word over on the valid-ready interface.
module tb_tdc_hit_encoder;
    import tdc_pkg::*;

    localparam int NTAP   = 55;
    localparam int FINE_W = 7;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 8;
    localparam int WORD_W = 1 + CNT_W + FINE_W;

    logic                  clk40M = 1'b0;
    logic                  rst;
    logic                  hit_valid;
    logic [NTAP-1:0]       fine_raw_code;
    logic [CNT_W-1:0]      counterA;
    logic [CNT_W-1:0]      counterB;
    logic                  enc_mode;
    logic [WORD_W-1:0]     out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            fifo_count;
    logic                  ovf;
    logic                  clr_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WORD_W-1:0] sb_q[$];

    tdc_hit_encoder #(
        .NTAP    (NTAP),
        .FINE_W  (FINE_W),
        .CNT_W   (CNT_W),
        .SEL_THR (28),
        .DEPTH   (DEPTH)
    ) dut (
        .clk40M        (clk40M),
        .rst           (rst),
        .hit_valid     (hit_valid),
        .fine_raw_code (fine_raw_code),
        .counterA      (counterA),
        .counterB      (counterB),
        .enc_mode      (enc_mode),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_count    (fifo_count),
        .ovf           (ovf),
        .clr_ovf       (clr_ovf)
    );

    always #5 clk40M = ~clk40M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk(input logic e, input logic [CNT_W-1:0] c,
                                             input logic [FINE_W-1:0] f);
        return {e, c, f};
    endfunction

    function automatic logic [NTAP-1:0] therm(input int k);
        logic [NTAP-1:0] r;
        r = '0;
        for (int i = 0; i < k; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Reference for a clean thermometer code with k leading ones.
    function automatic logic [WORD_W-1:0] model(input int k, input logic mode,
                                                input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        int f;
        if (!mode)          f = k;
        else if (k == 0)    f = 0;
        else if (k == NTAP) f = NTAP;
        else                f = k - 1;
        return mk(1'b0, (f >= 28) ? b : a, FINE_W'(f));
    endfunction

    // Monitor: sampled on the falling edge, between the bench's drive
    // points and the next rising edge.
    always @(negedge clk40M) begin
        if (!rst && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                chk("word", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk40M);
        #2;
    endtask

    task automatic send_hit(input logic [NTAP-1:0] raw, input logic [CNT_W-1:0] a,
                            input logic [CNT_W-1:0] b, input logic mode,
                            input logic keep, input logic [WORD_W-1:0] exp);
        hit_valid     = 1'b1;
        fine_raw_code = raw;
        counterA      = a;
        counterB      = b;
        enc_mode      = mode;
        if (keep) sb_q.push_back(exp);
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && (sb_q.size() != 0 || out_valid); i++) tick();
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NTAP-1:0] raw;
        logic [CNT_W-1:0] a, b;
        logic m;
        int k;

        rst = 1'b1; hit_valid = 1'b0; fine_raw_code = '0; counterA = '0; counterB = '0;
        enc_mode = ENC_ONES; out_ready = 1'b1; clr_ovf = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Latency: word appears after the second edge following the hit
        send_hit(therm(20), 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b0, 5'd3, 7'd20));
        tick();
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_data",  32'(out_data), 32'(mk(1'b0, 5'd3, 7'd20)));
        wait_drain("drain_lat");

        // Directed encodings, back to back
        raw = therm(20); raw[10] = 1'b0;
        send_hit(raw, 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b0, 5'd3, 7'd20));
        raw[32:30] = 3'b111;
        send_hit(raw, 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b1, 5'd3, 7'd23));
        send_hit(therm(30), 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b0, 5'd9, 7'd30));
        send_hit(therm(28), 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b0, 5'd9, 7'd28));
        send_hit(therm(27), 5'd3, 5'd9, ENC_ONES, 1'b1, mk(1'b0, 5'd3, 7'd27));
        send_hit(therm(41), 5'd3, 5'd9, ENC_TRANS, 1'b1, mk(1'b0, 5'd9, 7'd40));
        send_hit('0, 5'd3, 5'd9, ENC_TRANS, 1'b1, mk(1'b0, 5'd3, 7'd0));
        send_hit(therm(NTAP), 5'd3, 5'd9, ENC_TRANS, 1'b1, mk(1'b0, 5'd9, 7'd55));
        wait_drain("drain_directed");

        // Full-rate random burst with out_ready stalling one cycle in three
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, NTAP);
            m = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            out_ready = (i % 3 != 0);
            send_hit(therm(k), a, b, m, 1'b1, model(k, m, a, b));
        end
        out_ready = 1'b1;
        wait_drain("drain_random");

        // Push and pop in the same cycle while full
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send_hit(therm(i * 5), 5'(i), 5'(20 + i), ENC_ONES, 1'b1,
                     model(i * 5, 1'b0, 5'(i), 5'(20 + i)));
        send_hit(therm(50), 5'd1, 5'd2, ENC_ONES, 1'b1, model(50, 1'b0, 5'd1, 5'd2));
        tick();
        out_ready = 1'b1;
        tick();
        chk("full_pushpop_count", 32'(fifo_count), 32'd8);
        chk("full_pushpop_ovf",   32'(ovf), 32'd0);
        wait_drain("drain_pushpop");

        // Overflow: nine hits into a stalled FIFO, ninth dropped
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            send_hit(therm(i * 6), 5'(i), 5'(31 - i), ENC_ONES, (i < 8),
                     model(i * 6, 1'b0, 5'(i), 5'(31 - i)));
        tick(); tick(); tick();
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_set",   32'(ovf), 32'd1);
        chk("ovf_head",  32'(out_data), 32'(sb_q[0]));
        tick(); tick(); tick();
        chk("ovf_head_stable", 32'(out_data), 32'(sb_q[0]));
        out_ready = 1'b1;
        wait_drain("drain_ovf");
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Overflow coinciding with clr_ovf: set wins
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            send_hit(therm(NTAP - i), 5'(i), 5'(10 + i), ENC_TRANS, (i < 8),
                     model(NTAP - i, 1'b1, 5'(i), 5'(10 + i)));
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        out_ready = 1'b1;
        wait_drain("drain_setwins");

        // Reset one cycle after a hit: hit discarded, outputs cleared
        send_hit(therm(10), 5'd4, 5'd6, ENC_ONES, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("rst_async_ovf", 32'(ovf), 32'd0);
        tick();
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_count", 32'(fifo_count), 32'd0);
        chk("rst2_data",  32'(out_data), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        send_hit(therm(45), 5'd7, 5'd12, ENC_ONES, 1'b1, mk(1'b0, 5'd12, 7'd45));
        tick();
        chk("post_rst_lat_n1", 32'(out_valid), 32'd0);
        tick();
        chk("post_rst_lat_n2", 32'(out_valid), 32'd1);
        chk("post_rst_data",   32'(out_data), 32'(mk(1'b0, 5'd12, 7'd45)));
        wait_drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
